// File: rtl/seven_seg_multidigit_counter.sv
// seven_seg_multidigit_counter: prescaled N-digit BCD up/down counter driving a multiplexed 7-segment display.
// Latency: count_bcd/tick_out/carry_out registered on the step edge; segments/digit_sel registered 1 cycle after scan index.
// Backpressure: none; en holds the count while the scan free-runs. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_multidigit_counter #(
    parameter int MAX_COUNT  = 1000,
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clear,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    tick_out,
    output logic                    carry_out
);

    // Prescaler, scan index and scan divider widths; each is held at >= 1 bit
    // so degenerate parameter values still elaborate.
    localparam int PW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(MAX_COUNT);

    // 0-9 to gfedcba; anything else cannot be stored, so it decodes dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0]           presc;
    logic                    step;
    logic [4*NUM_DIGITS-1:0] count_nxt;
    logic                    ripple;
    logic [3:0]              d_cur;
    logic [IW-1:0]           scan_idx;
    logic [NUM_DIGITS-1:0]   sel_nxt;
    logic [3:0]              cur_digit;
    logic                    cur_blank;

    // A count step happens only at prescaler terminal with en high; clear
    // outranks it so no tick or carry escapes on a clearing edge.
    assign step = en && !clear && (presc == PRESC_MAX);

    // Prescaler: counts 0..MAX_COUNT while enabled, freezes when en drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (en) begin
            if (presc == PRESC_MAX) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Ripple-carry/borrow BCD successor of the current count; ripple left set
    // after the top digit means the whole range wrapped.
    always_comb begin
        count_nxt = count_bcd;
        ripple    = 1'b1;
        d_cur     = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d_cur = count_bcd[4*k +: 4];
            if (ripple) begin
                if (up_dn) begin
                    if (d_cur == 4'd9) begin
                        count_nxt[4*k +: 4] = 4'd0;
                    end else begin
                        count_nxt[4*k +: 4] = d_cur + 4'd1;
                        ripple              = 1'b0;
                    end
                end else begin
                    if (d_cur == 4'd0) begin
                        count_nxt[4*k +: 4] = 4'd9;
                    end else begin
                        count_nxt[4*k +: 4] = d_cur - 4'd1;
                        ripple              = 1'b0;
                    end
                end
            end
        end
    end

    // Digit register plus the tick/carry pulses, all updated on the step edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_bcd <= '0;
            tick_out  <= 1'b0;
            carry_out <= 1'b0;
        end else if (clear) begin
            count_bcd <= '0;
            tick_out  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            tick_out  <= step;
            carry_out <= step && ripple;
            if (step) begin
                count_bcd <= count_nxt;
            end
        end
    end

    generate
        if (NUM_DIGITS > 1) begin : g_scan
            localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
            localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

            logic [SW-1:0] scan_div;
            logic [IW-1:0] idx_q;

            // Free-running scan: hold each digit SCAN_DIV clocks, then move on.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    scan_div <= '0;
                    idx_q    <= '0;
                end else if (scan_div == SCAN_MAX) begin
                    scan_div <= '0;
                    idx_q    <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                end else begin
                    scan_div <= scan_div + 1'b1;
                end
            end

            assign scan_idx = idx_q;
        end else begin : g_no_scan
            // A single digit is always selected; nothing to scan.
            assign scan_idx = '0;
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;

    // lead_zero[k]: digit k and every more-significant digit are zero.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (count_bcd[4*k +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end
    end
`endif

    // Select the scanned digit and build its one-hot strobe.
    always_comb begin
        sel_nxt   = '0;
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx == IW'(k)) begin
                sel_nxt[k] = 1'b1;
                cur_digit  = count_bcd[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                // The units digit always shows, even when the count is zero.
                cur_blank  = (k != 0) && lead_zero[k];
`endif
            end
        end
    end

    // Register the display bus so segments and strobe move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments  <= 7'h3F;
            digit_sel <= NUM_DIGITS'(1);
        end else begin
            segments  <= cur_blank ? 7'h00 : seg_decode(cur_digit);
            digit_sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_multidigit_counter.sv
// tb_seven_seg_multidigit_counter: scoreboard-driven bench for the multiplexed BCD counter.
// Latency: expected count/carry queued before each step, popped when tick_out is seen.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_seven_seg_multidigit_counter;

    localparam int MAX_COUNT  = 3;
    localparam int NUM_DIGITS = 2;
    localparam int SCAN_DIV   = 2;
    localparam int PERIOD     = MAX_COUNT + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic [6:0] segments;
    logic [1:0] digit_sel;
    logic [7:0] count_bcd;
    logic       tick_out;
    logic       carry_out;

    typedef struct packed {
        logic [7:0] bcd;
        logic       carry;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   model_val = 0;

    seven_seg_multidigit_counter #(
        .MAX_COUNT  (MAX_COUNT),
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .clear     (clear),
        .segments  (segments),
        .digit_sel (digit_sel),
        .count_bcd (count_bcd),
        .tick_out  (tick_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Waits (bounded) for a tick; cycles counts negedges consumed.
    task automatic wait_tick(input int limit, output int cycles, output bit got);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (tick_out === 1'b1) got = 1'b1;
        end
    endtask

    // Moves the count along without checking; the caller checks misses.
    task automatic advance_ticks(input int n, output int misses);
        int c;
        bit g;
        misses = 0;
        for (int i = 0; i < n; i++) begin
            wait_tick(4 * PERIOD, c, g);
            if (!g) misses++;
            else model_val = up_dn ? (model_val + 1) % 100 : (model_val + 99) % 100;
        end
    endtask

    task automatic test_reset();
        int   c;
        bit   g;
        exp_t e;
        rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; clear = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", count_bcd); end
        n_checks++;
        if (tick_out !== 1'b0 || carry_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: tick %b carry %b want 0 0", tick_out, carry_out);
        end
        n_checks++;
        if (digit_sel !== 2'b01) begin n_fail++; $display("FAIL reset_digit_sel: got %b want 01", digit_sel); end
        n_checks++;
        if (segments !== 7'h3F) begin n_fail++; $display("FAIL reset_segments: got %h want 3f", segments); end

        rst_n     = 1'b1;
        model_val = 1;
        sb_q.push_back(exp_t'{bcd: to_bcd(1), carry: 1'b0});
        wait_tick(4 * PERIOD, c, g);
        n_checks++;
        if (!g || c != PERIOD) begin n_fail++; $display("FAIL first_tick_latency: got %0d cycles (seen %0d) want %0d", c, g, PERIOD); end
        e = sb_q.pop_front();
        n_checks++;
        if (count_bcd !== e.bcd || carry_out !== e.carry) begin
            n_fail++; $display("FAIL first_tick_value: got %h/%b want %h/%b", count_bcd, carry_out, e.bcd, e.carry);
        end
        @(negedge clk);
        n_checks++;
        if (tick_out !== 1'b0) begin n_fail++; $display("FAIL tick_width: tick still %b one cycle later, want 0", tick_out); end

        for (int i = 0; i < 9; i++) begin
            model_val++;
            sb_q.push_back(exp_t'{bcd: to_bcd(model_val), carry: 1'b0});
            wait_tick(4 * PERIOD, c, g);
            e = sb_q.pop_front();
            n_checks++;
            if (!g || count_bcd !== e.bcd || carry_out !== e.carry) begin
                n_fail++; $display("FAIL up_step: got %h/%b (seen %0d) want %h/%b", count_bcd, carry_out, g, e.bcd, e.carry);
            end
        end
        n_checks++;
        if (count_bcd !== 8'h10) begin n_fail++; $display("FAIL ten_ticks: got %h want 10", count_bcd); end
    endtask

    task automatic test_up_wrap();
        int   c;
        bit   g;
        int   prev;
        exp_t e;
        up_dn = 1'b1;
        for (int i = 0; i < 90; i++) begin
            prev      = model_val;
            model_val = (prev + 1) % 100;
            sb_q.push_back(exp_t'{bcd: to_bcd(model_val), carry: (prev == 99)});
            wait_tick(4 * PERIOD, c, g);
            e = sb_q.pop_front();
            n_checks++;
            if (!g || count_bcd !== e.bcd || carry_out !== e.carry) begin
                n_fail++; $display("FAIL up_wrap_step: got %h/%b (seen %0d) want %h/%b", count_bcd, carry_out, g, e.bcd, e.carry);
            end
        end
        @(negedge clk);
        n_checks++;
        if (carry_out !== 1'b0) begin n_fail++; $display("FAIL up_carry_width: carry %b one cycle later, want 0", carry_out); end
    endtask

    task automatic test_down_wrap();
        int   c;
        bit   g;
        exp_t e;
        up_dn = 1'b0;
        sb_q.push_back(exp_t'{bcd: 8'h99, carry: 1'b1});
        sb_q.push_back(exp_t'{bcd: 8'h98, carry: 1'b0});
        for (int i = 0; i < 2; i++) begin
            wait_tick(4 * PERIOD, c, g);
            e = sb_q.pop_front();
            n_checks++;
            if (!g || count_bcd !== e.bcd || carry_out !== e.carry) begin
                n_fail++; $display("FAIL down_wrap_step%0d: got %h/%b (seen %0d) want %h/%b", i, count_bcd, carry_out, g, e.bcd, e.carry);
            end
        end
        model_val = 98;
    endtask

    task automatic test_clear_vs_step();
        int   c;
        bit   g;
        int   misses;
        exp_t e;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; up_dn = 1'b1; en = 1'b1; model_val = 0;
        advance_ticks(42, misses);
        n_checks++;
        if (misses != 0 || count_bcd !== 8'h42) begin
            n_fail++; $display("FAIL reach_42: got %h (missed %0d) want 42", count_bcd, misses);
        end
        repeat (PERIOD - 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (count_bcd !== 8'h00 || tick_out !== 1'b0 || carry_out !== 1'b0) begin
            n_fail++; $display("FAIL clear_on_step: got %h tick %b carry %b want 00 0 0", count_bcd, tick_out, carry_out);
        end
        model_val = 1;
        sb_q.push_back(exp_t'{bcd: 8'h01, carry: 1'b0});
        wait_tick(4 * PERIOD, c, g);
        e = sb_q.pop_front();
        n_checks++;
        if (!g || c != PERIOD || count_bcd !== e.bcd) begin
            n_fail++; $display("FAIL after_clear_tick: got %h after %0d cycles want %h after %0d", count_bcd, c, e.bcd, PERIOD);
        end
    endtask

    task automatic test_enable_hold();
        int   c;
        bit   g;
        bit   saw_tick;
        bit   moved;
        exp_t e;
        repeat (2) @(negedge clk);
        en = 1'b0; saw_tick = 1'b0; moved = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tick_out !== 1'b0) saw_tick = 1'b1;
            if (count_bcd !== 8'h01) moved = 1'b1;
        end
        n_checks++;
        if (saw_tick || moved) begin
            n_fail++; $display("FAIL enable_hold: tick seen %0d count %h want no tick and 01", saw_tick, count_bcd);
        end
        en = 1'b1;
        model_val = 2;
        sb_q.push_back(exp_t'{bcd: 8'h02, carry: 1'b0});
        wait_tick(4 * PERIOD, c, g);
        e = sb_q.pop_front();
        n_checks++;
        if (!g || c != PERIOD - 2 || count_bcd !== e.bcd) begin
            n_fail++; $display("FAIL enable_resume: got %h after %0d cycles want %h after %0d", count_bcd, c, e.bcd, PERIOD - 2);
        end
    endtask

    task automatic test_async_reset();
        int c;
        bit g;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (count_bcd !== 8'h00 || digit_sel !== 2'b01 || segments !== 7'h3F || tick_out !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %h %b %h %b want 00 01 3f 0", count_bcd, digit_sel, segments, tick_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_val = 1;
        wait_tick(4 * PERIOD, c, g);
        n_checks++;
        if (!g || c != PERIOD || count_bcd !== 8'h01) begin
            n_fail++; $display("FAIL reset_restart: got %h after %0d cycles want 01 after %0d", count_bcd, c, PERIOD);
        end
    endtask

    task automatic test_scan();
        int         misses;
        logic [1:0] prev_sel;
        int         run;
        int         changes;
        logic [6:0] want;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; en = 1'b1; up_dn = 1'b1; model_val = 0;
        advance_ticks(47, misses);
        en = 1'b0;
        n_checks++;
        if (misses != 0 || count_bcd !== 8'h47) begin
            n_fail++; $display("FAIL reach_47: got %h (missed %0d) want 47", count_bcd, misses);
        end
        prev_sel = digit_sel; run = 0; changes = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            want = (digit_sel == 2'b01) ? 7'h07 : 7'h66;
            n_checks++;
            if ((digit_sel != 2'b01 && digit_sel != 2'b10) || segments !== want) begin
                n_fail++; $display("FAIL scan_47: sel %b seg %h want one-hot sel with seg %h", digit_sel, segments, want);
            end
            if (digit_sel !== prev_sel) begin
                if (changes > 0) begin
                    n_checks++;
                    if (run != SCAN_DIV) begin n_fail++; $display("FAIL scan_dwell: held %0d cycles want %0d", run, SCAN_DIV); end
                end
                changes++;
                run = 1;
            end else begin
                run++;
            end
            prev_sel = digit_sel;
        end
        n_checks++;
        if (changes < 4) begin n_fail++; $display("FAIL scan_alternates: %0d changes in 12 cycles want >= 4", changes); end
    endtask

    task automatic test_blanking();
        int         misses;
        logic [6:0] want;
        logic [6:0] lead_seg;
        bit         seen_lo;
        bit         seen_hi;
`ifdef LEADING_ZERO_BLANK_EN
        lead_seg = 7'h00;
`else
        lead_seg = 7'h3F;
`endif
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; en = 1'b1; up_dn = 1'b1; model_val = 0;
        advance_ticks(5, misses);
        en = 1'b0;
        n_checks++;
        if (misses != 0 || count_bcd !== 8'h05) begin
            n_fail++; $display("FAIL reach_05: got %h (missed %0d) want 05", count_bcd, misses);
        end
        seen_lo = 1'b0; seen_hi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (digit_sel == 2'b01) seen_lo = 1'b1;
            if (digit_sel == 2'b10) seen_hi = 1'b1;
            want = (digit_sel == 2'b01) ? 7'h6D : lead_seg;
            n_checks++;
            if (segments !== want) begin n_fail++; $display("FAIL blank_05: sel %b seg %h want %h", digit_sel, segments, want); end
        end
        // Clear must act with en low.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (count_bcd !== 8'h00) begin n_fail++; $display("FAIL clear_en_low: got %h want 00", count_bcd); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (digit_sel == 2'b01) seen_lo = 1'b1;
            if (digit_sel == 2'b10) seen_hi = 1'b1;
            want = (digit_sel == 2'b01) ? 7'h3F : lead_seg;
            n_checks++;
            if (segments !== want) begin n_fail++; $display("FAIL blank_00: sel %b seg %h want %h", digit_sel, segments, want); end
        end
        n_checks++;
        if (!seen_lo || !seen_hi) begin n_fail++; $display("FAIL blank_coverage: lo %0d hi %0d want both 1", seen_lo, seen_hi); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_clear_vs_step();
        test_enable_hold();
        test_async_reset();
        test_scan();
        test_blanking();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
